axi_slave_mem: RTL and testbench
================================

# axi_slave_mem

AXI4 memory-mapped slave that terminates the traffic produced by the smoke, random and burst sequences driven through the AXI master agent. It is the RTL target at the far end of the agent's interface: it accepts write and read bursts (FIXED, INCR, WRAP), stores data in an internal word array and returns B/R responses with error signalling. There is one independent FSM per direction and one outstanding transaction per direction.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width (32 or 64); bytes per beat NB = DATA_W/8
- ID_W, 4, transaction ID width
- MEM_DEPTH, 1024, number of DATA_W words in the array
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address channel
- awvalid in 1, awready out 1  write address handshake
- wdata/wstrb/wlast  in  DATA_W/NB/1  write data channel
- wvalid in 1, wready out 1  write data handshake
- bid/bresp  out  ID_W/2  write response
- bvalid out 1, bready in 1  write response handshake
- arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address channel
- arvalid in 1, arready out 1  read address handshake
- rid/rdata/rresp/rlast  out  ID_W/DATA_W/2/1  read data channel
- rvalid out 1, rready in 1  read data handshake

## Operation
- Write FSM has states W_IDLE, W_DATA and W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size and burst; clear the error flag; go to W_DATA.
  - W_DATA: wready=1. Each W handshake is one beat. Bytes with wstrb[i]=1 are written to mem[word index]. The beat counter increments. After beat awlen+1, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id. On B handshake, go to W_IDLE.
- Read FSM has states R_IDLE and R_DATA.
  - R_IDLE: arready=1. On AR handshake, latch the address fields and go to R_DATA.
  - R_DATA: rvalid=1. rdata is an asynchronous read of mem at the current beat address. rlast=1 on beat arlen. An R handshake advances the beat. The final handshake returns the FSM to R_IDLE.
- Word index = addr >> log2(NB). Next-address rules:
  - FIXED: unchanged.
  - INCR: addr + NB.
  - WRAP: boundary = addr aligned down to (len+1)*NB; next = boundary + ((addr + NB − boundary) mod ((len+1)*NB)).
- Error conditions (any of these gives SLVERR = 2'b10):
  - axsize ≠ log2(NB)
  - axburst = 2'b11
  - WRAP with len ∉ {1,3,7,15}
  - word index ≥ MEM_DEPTH
- Error handling:
  - Burst-level errors suppress every write of the burst and return rdata=0 with SLVERR on every read beat.
  - Out-of-range errors act per beat: that beat is not written / returns rdata=0 with SLVERR.
  - Write side: bresp = SLVERR if any beat errored, else OKAY (2'b00).
- Write beat count is authoritative. A wlast mismatch (wlast=1 before the final beat, or wlast=0 on it) does not change termination; it sets SLVERR.
- Read and write are fully independent. A read of a word written in the same cycle returns the old data.
- Memory is not reset.

## Timing
- During reset all outputs = 0 (awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata). FSMs go to idle.
- First cycle after reset: awready=1, arready=1.
- Reset asserted mid-burst abandons the transaction: no B or R response, and the next cycle's outputs are 0.
- Write timing:
  - AW handshake at cycle T → awready=0 and wready=1 at T+1.
  - Final W handshake at L → wready=0 and bvalid=1 at L+1.
  - B handshake at M → bvalid=0 and awready=1 at M+1.
- Read timing:
  - AR handshake at T → rvalid=1 with beat 0 at T+1.
  - Throughput is one beat per cycle while rready=1.
  - Final R handshake at L → rvalid=0 and arready=1 at L+1.
- Handshake rules:
  - bvalid and rvalid hold, with stable payload, until accepted.
  - awready and arready never depend combinationally on awvalid or arvalid.
- Minimum write transaction: 3 cycles idle-to-idle. Minimum single-beat read: 2 cycles.

## Test plan
- Smoke: write INCR len=0, addr 0x10, data 0xDEADBEEF, wstrb 0xF → bresp=OKAY, bvalid at L+1. Read addr 0x10 → rdata=0xDEADBEEF, rlast=1, rresp=OKAY.
- INCR len=7 from 0x100 with data i+1, then read back with rready toggling every other cycle → 8 beats 1..8 in order, rlast only on beat 8, payload stable while stalled.
- WRAP len=3 from 0x38 (NB=4) → writes land at words 0x38, 0x3C, 0x30, 0x34. WRAP len=2 → SLVERR and no memory change.
- Partial strobe: write 0xFFFFFFFF, then 0x11223344 with wstrb 0x5 → readback 0xFF22FF44.
- Error paths:
  - Address MEM_DEPTH*NB → bresp=SLVERR, rresp=SLVERR with rdata=0.
  - awsize=1 → SLVERR, no write.
  - wlast early on beat 1 of len=3 → 4 beats still accepted, bresp=SLVERR.
- areset asserted during beat 2 of an 8-beat write, and simultaneously mid-read → all outputs 0 next cycle, no B or R response, awready=arready=1 after release, and a new transaction completes normally.

Source files
------------

// File: rtl/axi_slave_mem.sv
// axi_slave_mem
// AXI4 memory-mapped slave backed by an internal word array.
// Accepts FIXED / INCR / WRAP bursts with one outstanding transaction per
// direction; the write and read sides run independent FSMs.
//
// Ports
//   aclk, areset            clock, synchronous active-high reset
//   aw* / awvalid, awready  write address channel
//   w*  / wvalid,  wready   write data channel
//   b*  / bvalid,  bready   write response channel
//   ar* / arvalid, arready  read address channel
//   r*  / rvalid,  rready   read data channel (rdata is an async array read)
module axi_slave_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int NB   = DATA_W / 8;
  localparam int LSB  = $clog2(NB);
  localparam int MA_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] NB_A    = ADDR_W'(NB);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Errors that poison the whole burst, decided once at address accept.
  function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != 3'(LSB)) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  // WRAP span is a power of two whenever the burst is legal, so the
  // modulo and the align-down both reduce to masking.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0] len,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] span, mask, bnd;
    span = (ADDR_W'(len) + ADDR_W'(1)) << LSB;
    mask = span - ADDR_W'(1);
    bnd  = addr & ~mask;
    case (burst)
      2'b01:   next_addr = addr + NB_A;
      2'b10:   next_addr = bnd + ((addr + NB_A - bnd) & mask);
      default: next_addr = addr;
    endcase
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t          w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [1:0]        w_burst_q, w_burst_d;
  logic              w_berr_q, w_berr_d, w_err_q, w_err_d;
  logic              w_we;

  r_state_t          r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [7:0]        r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic              r_berr_q, r_berr_d;

  logic [ADDR_W-1:0] w_idx, r_idx;
  logic              w_oob, r_oob, w_final, r_final;
  logic [MA_W-1:0]   w_mem_addr, r_mem_addr;
  logic [DATA_W-1:0] r_word;

  assign w_idx      = w_addr_q >> LSB;
  assign r_idx      = r_addr_q >> LSB;
  assign w_oob      = (w_idx >= DEPTH_A);
  assign r_oob      = (r_idx >= DEPTH_A);
  assign w_mem_addr = w_idx[MA_W-1:0];
  assign r_mem_addr = r_idx[MA_W-1:0];
  assign w_final    = (w_beat_q == w_len_q);
  assign r_final    = (r_beat_q == r_len_q);

  // One byte-wide array per lane so strobed writes need no read-modify-write.
  // The read port is combinational: a same-cycle write is seen next cycle.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_q [MEM_DEPTH];
    always_ff @(posedge aclk) begin
      if (w_we && wstrb[gi]) begin
        lane_q[w_mem_addr] <= wdata[gi*8 +: 8];
      end
    end
    assign r_word[gi*8 +: 8] = lane_q[r_mem_addr];
  end

  // Write side. Every output is forced low while reset is high.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_burst_d = w_burst_q;
    w_berr_d  = w_berr_q;
    w_err_d   = w_err_q;
    w_beat_d  = w_beat_q;
    w_we      = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bid       = '0;
    bresp     = RESP_OKAY;
    if (!areset) begin
      case (w_state_q)
        W_IDLE: begin
          awready = 1'b1;
          if (awvalid) begin
            w_id_d    = awid;
            w_addr_d  = awaddr;
            w_len_d   = awlen;
            w_burst_d = awburst;
            w_berr_d  = burst_bad(awsize, awburst, awlen);
            w_err_d   = 1'b0;
            w_beat_d  = 8'd0;
            w_state_d = W_DATA;
          end
        end
        W_DATA: begin
          wready = 1'b1;
          if (wvalid) begin
            w_we = !w_berr_q && !w_oob;
            // The beat count ends the burst; a misplaced wlast only flags it.
            if (w_berr_q || w_oob || (wlast != w_final)) begin
              w_err_d = 1'b1;
            end
            w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
            w_beat_d = w_beat_q + 8'd1;
            if (w_final) begin
              w_state_d = W_RESP;
            end
          end
        end
        W_RESP: begin
          bvalid = 1'b1;
          bid    = w_id_q;
          bresp  = w_err_q ? RESP_SLVERR : RESP_OKAY;
          if (bready) begin
            w_state_d = W_IDLE;
          end
        end
        default: w_state_d = W_IDLE;
      endcase
    end
  end

  // Read side.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_berr_d  = r_berr_q;
    r_beat_d  = r_beat_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rid       = '0;
    rdata     = '0;
    rresp     = RESP_OKAY;
    rlast     = 1'b0;
    if (!areset) begin
      case (r_state_q)
        R_IDLE: begin
          arready = 1'b1;
          if (arvalid) begin
            r_id_d    = arid;
            r_addr_d  = araddr;
            r_len_d   = arlen;
            r_burst_d = arburst;
            r_berr_d  = burst_bad(arsize, arburst, arlen);
            r_beat_d  = 8'd0;
            r_state_d = R_DATA;
          end
        end
        R_DATA: begin
          rvalid = 1'b1;
          rid    = r_id_q;
          rlast  = r_final;
          if (r_berr_q || r_oob) begin
            rresp = RESP_SLVERR;
          end else begin
            rdata = r_word;
          end
          if (rready) begin
            r_addr_d = next_addr(r_addr_q, r_len_q, r_burst_q);
            r_beat_d = r_beat_q + 8'd1;
            if (r_final) begin
              r_state_d = R_IDLE;
            end
          end
        end
        default: r_state_d = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= '0;
      w_berr_q  <= 1'b0;
      w_err_q   <= 1'b0;
      w_beat_q  <= '0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_berr_q  <= 1'b0;
      r_beat_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_berr_q  <= w_berr_d;
      w_err_q   <= w_err_d;
      w_beat_q  <= w_beat_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_berr_q  <= r_berr_d;
      r_beat_q  <= r_beat_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Testbench for axi_slave_mem: directed cases plus randomized bursts,
// checked against a transaction-level memory model held in the bench.
module tb_axi_slave_mem;
  localparam int MD = 1024;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_slave_mem #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_DEPTH(MD)) dut (
    .aclk(clk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdl [MD];
  logic [31:0] tb_wdata [256];
  logic [3:0]  tb_wstrb [256];
  logic [31:0] rd_got [256];
  logic [1:0]  rd_resp [256];
  logic [1:0]  got_bresp;
  b_exp_t      bq[$];
  r_exp_t      rq[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [7:0] len);
    return (size != 3'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  // Address of beat i, computed directly rather than stepwise.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [1:0] burst, input int i);
    longint total, lower;
    total = (longint'(len) + 1) * 4;
    case (burst)
      2'b00: return a;
      2'b10: begin
        lower = (longint'(a) / total) * total;
        return 32'(lower + ((longint'(a) - lower + longint'(i) * 4) % total));
      end
      default: return 32'(longint'(a) + longint'(i) * 4);
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (areset) begin
      chk("reset_outputs", 64'({awready, wready, bvalid, arready, rvalid, rlast,
                                bresp, rresp, bid, rid, rdata}), 64'd0);
    end else begin
      if (bvalid) begin
        if (bq.size() == 0) chk("b_unexpected", 64'(bvalid), 64'd0);
        else begin
          chk("b_payload", 64'({bid, bresp}), 64'(bq[0]));
          if (bready) void'(bq.pop_front());
        end
      end
      if (rvalid) begin
        if (rq.size() == 0) chk("r_unexpected", 64'(rvalid), 64'd0);
        else begin
          chk("r_payload", 64'({rid, rdata, rresp, rlast}), 64'(rq[0]));
          if (rready) void'(rq.pop_front());
        end
      end
    end
  end

  // ---------------- drivers (entered just after a rising edge) ----------------
  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst,
                    input int flip_last, input int bstall);
    bit   bad;
    logic err;
    int   n;
    b_exp_t e;
    bad = burst_bad(size, burst, len);
    err = bad;
    n   = int'(len) + 1;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = beat_addr(addr, len, burst, i);
      if (i == flip_last) err = 1'b1;
      if (a >= 32'(MD * 4)) err = 1'b1;
      else if (!bad) begin
        for (int b = 0; b < 4; b++)
          if (tb_wstrb[i][b]) mdl[a[11:2]][8*b +: 8] = tb_wdata[i][8*b +: 8];
      end
    end
    e.id = id; e.resp = err ? 2'b10 : 2'b00;
    bq.push_back(e);

    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    @(negedge clk); chk("awready_idle", 64'(awready), 64'd1);
    @(posedge clk); #1; awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0; @(posedge clk); #1;
      end
      wvalid = 1'b1; wdata = tb_wdata[i]; wstrb = tb_wstrb[i];
      wlast  = ((i == n - 1) != (i == flip_last));
      @(negedge clk);
      chk("wready_beat", 64'(wready), 64'd1);
      if (i == 0) chk("aw_to_w_awready", 64'(awready), 64'd0);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = (bstall == 0);
    @(negedge clk);
    chk("w_to_b_wready", 64'(wready), 64'd0);
    chk("w_to_b_bvalid", 64'(bvalid), 64'd1);
    got_bresp = bresp;
    for (int s = 0; s < bstall; s++) begin
      @(posedge clk); #1;
      if (s == bstall - 1) bready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1; bready = 1'b0;
    @(negedge clk);
    chk("b_to_idle_bvalid", 64'(bvalid), 64'd0);
    chk("b_to_idle_awready", 64'(awready), 64'd1);
    @(posedge clk); #1;
    $display("[TB] WR id=%0d addr=%h len=%0d size=%0d burst=%0d bresp=%0d",
             id, addr, len, size, burst, got_bresp);
  endtask

  // rmode: 0 rready held high, 1 toggling, 2 random (at most one stall per beat)
  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input int rmode);
    bit bad;
    int n, got, cyc;
    bad = burst_bad(size, burst, len);
    n   = int'(len) + 1;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      r_exp_t e;
      bit err;
      a = beat_addr(addr, len, burst, i);
      err = bad || (a >= 32'(MD * 4));
      e.id = id; e.last = (i == n - 1);
      e.resp = err ? 2'b10 : 2'b00;
      e.data = err ? 32'd0 : mdl[a[11:2]];
      rq.push_back(e);
    end
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    @(negedge clk); chk("arready_idle", 64'(arready), 64'd1);
    @(posedge clk); #1; arvalid = 1'b0;
    got = 0; cyc = 0;
    while (got < n && cyc < 2 * n + 4) begin
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 2 == 1);
        default: rready = (cyc % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      chk("rvalid_in_burst", 64'(rvalid), 64'd1);
      if (rvalid && rready) begin
        rd_got[got] = rdata; rd_resp[got] = rresp; got++;
      end
      @(posedge clk); #1; cyc++;
    end
    if (got < n) chk("r_beat_budget", 64'(got), 64'(n));
    rready = 1'b0;
    @(negedge clk);
    chk("r_to_idle_rvalid", 64'(rvalid), 64'd0);
    chk("r_to_idle_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;
    $display("[TB] RD id=%0d addr=%h len=%0d size=%0d burst=%0d beat0=%h",
             id, addr, len, size, burst, rd_got[0]);
  endtask

  task automatic set_beats(input int n, input logic [31:0] base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      tb_wdata[i] = rnd ? $urandom : base + 32'(i);
      tb_wstrb[i] = 4'hF;
    end
  endtask

  initial begin
    areset = 1'b1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) @(posedge clk);
    #1; areset = 1'b0;
    @(negedge clk);
    chk("post_reset_awready", 64'(awready), 64'd1);
    chk("post_reset_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;

    // Give the whole array known contents.
    for (int k = 0; k < 4; k++) begin
      set_beats(256, 0, 1'b1);
      wr(4'd0, 32'(k * 1024), 8'd255, 3'd2, 2'b01, -1, 0);
    end

    // Smoke
    tb_wdata[0] = 32'hDEADBEEF; tb_wstrb[0] = 4'hF;
    wr(4'd1, 32'h10, 8'd0, 3'd2, 2'b01, -1, 0);
    chk("smoke_bresp", 64'(got_bresp), 64'd0);
    chk("smoke_model", 64'(mdl[4]), 64'hDEADBEEF);
    rd(4'd2, 32'h10, 8'd0, 3'd2, 2'b01, 0);
    chk("smoke_rdata", 64'(rd_got[0]), 64'hDEADBEEF);
    chk("smoke_rresp", 64'(rd_resp[0]), 64'd0);

    // INCR 8 beats, read back with toggling rready
    set_beats(8, 32'd1, 1'b0);
    wr(4'd3, 32'h100, 8'd7, 3'd2, 2'b01, -1, 2);
    rd(4'd4, 32'h100, 8'd7, 3'd2, 2'b01, 1);
    for (int i = 0; i < 8; i++) chk("incr8_beat", 64'(rd_got[i]), 64'(i + 1));

    // WRAP len=3 from 0x38
    set_beats(4, 32'd1, 1'b0);
    wr(4'd5, 32'h38, 8'd3, 3'd2, 2'b10, -1, 0);
    chk("wrap_m38", 64'(mdl[14]), 64'd1);
    chk("wrap_m3c", 64'(mdl[15]), 64'd2);
    chk("wrap_m30", 64'(mdl[12]), 64'd3);
    chk("wrap_m34", 64'(mdl[13]), 64'd4);
    rd(4'd6, 32'h30, 8'd3, 3'd2, 2'b01, 0);
    chk("wrap_rd0", 64'(rd_got[0]), 64'd3);
    chk("wrap_rd1", 64'(rd_got[1]), 64'd4);
    chk("wrap_rd2", 64'(rd_got[2]), 64'd1);
    chk("wrap_rd3", 64'(rd_got[3]), 64'd2);

    // WRAP len=2 is illegal: SLVERR, memory untouched
    set_beats(3, 32'h5A5A0000, 1'b0);
    wr(4'd7, 32'h200, 8'd2, 3'd2, 2'b10, -1, 1);
    chk("wrap2_bresp", 64'(got_bresp), 64'd2);
    rd(4'd7, 32'h200, 8'd2, 3'd2, 2'b01, 2);
    rd(4'd8, 32'h200, 8'd2, 3'd2, 2'b10, 0);
    chk("wrap2_rresp", 64'(rd_resp[0]), 64'd2);

    // Partial strobe
    tb_wdata[0] = 32'hFFFFFFFF; tb_wstrb[0] = 4'hF;
    wr(4'd9, 32'h80, 8'd0, 3'd2, 2'b00, -1, 0);
    tb_wdata[0] = 32'h11223344; tb_wstrb[0] = 4'h5;
    wr(4'd9, 32'h80, 8'd0, 3'd2, 2'b00, -1, 0);
    chk("strobe_model", 64'(mdl[32]), 64'hFF22FF44);
    rd(4'd10, 32'h80, 8'd0, 3'd2, 2'b01, 0);
    chk("strobe_rdata", 64'(rd_got[0]), 64'hFF22FF44);

    // Out of range
    tb_wdata[0] = 32'h12345678; tb_wstrb[0] = 4'hF;
    wr(4'd11, 32'(MD * 4), 8'd0, 3'd2, 2'b01, -1, 0);
    chk("oob_bresp", 64'(got_bresp), 64'd2);
    rd(4'd11, 32'(MD * 4), 8'd0, 3'd2, 2'b01, 0);
    chk("oob_rdata", 64'(rd_got[0]), 64'd0);
    chk("oob_rresp", 64'(rd_resp[0]), 64'd2);

    // Bad size: no write
    tb_wdata[0] = 32'hCAFEF00D; tb_wstrb[0] = 4'hF;
    wr(4'd12, 32'h84, 8'd0, 3'd1, 2'b01, -1, 0);
    chk("size_bresp", 64'(got_bresp), 64'd2);
    rd(4'd12, 32'h84, 8'd0, 3'd2, 2'b01, 0);

    // Early wlast on beat 1 of 4: all beats still accepted
    set_beats(4, 32'hA0, 1'b0);
    wr(4'd13, 32'h180, 8'd3, 3'd2, 2'b01, 1, 0);
    chk("wlast_bresp", 64'(got_bresp), 64'd2);
    rd(4'd13, 32'h180, 8'd3, 3'd2, 2'b01, 0);

    // Reset during beat 2 of an 8-beat write and mid-read
    set_beats(8, 32'h7700, 1'b0);
    for (int i = 0; i < 2; i++) begin
      r_exp_t e;
      e.id = 4'd6; e.data = mdl[64 + i]; e.resp = 2'b00; e.last = 1'b0;
      rq.push_back(e);
    end
    mdl[192] = tb_wdata[0];
    mdl[193] = tb_wdata[1];
    awvalid = 1; awid = 4'd5; awaddr = 32'h300; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01;
    arvalid = 1; arid = 4'd6; araddr = 32'h100; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
    @(posedge clk); #1;
    awvalid = 0; arvalid = 0;
    wvalid = 1; wdata = tb_wdata[0]; wstrb = 4'hF; wlast = 0; rready = 1;
    @(posedge clk); #1; wdata = tb_wdata[1];
    @(posedge clk); #1; wdata = tb_wdata[2]; areset = 1'b1;
    @(posedge clk); #1; wvalid = 0; rready = 0;
    @(posedge clk); #1; areset = 1'b0;
    chk("rst_rq_drained", 64'(rq.size()), 64'd0);
    bq.delete(); rq.delete();
    @(negedge clk);
    chk("rst_release_ready", 64'({awready, arready, bvalid, rvalid}), 64'b1100);
    repeat (3) @(posedge clk);
    #1;
    set_beats(8, 32'h8800, 1'b1);
    wr(4'd14, 32'h308, 8'd5, 3'd2, 2'b01, -1, 0);
    rd(4'd15, 32'h300, 8'd7, 3'd2, 2'b01, 0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [1:0]  bu;
      logic [7:0]  ln;
      logic [2:0]  sz;
      logic [31:0] ad;
      int r, fl;
      r  = $urandom_range(0, 9);
      bu = (r < 2) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if (bu == 2'b10) begin
        r  = $urandom_range(0, 4);
        ln = (r == 0) ? 8'd1 : (r == 1) ? 8'd3 : (r == 2) ? 8'd7 : (r == 3) ? 8'd15 : 8'd2;
      end else ln = 8'($urandom_range(0, 15));
      sz = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      ad = 32'($urandom_range(0, MD + 8)) << 2;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= int'(ln); i++) begin
          tb_wdata[i] = $urandom;
          tb_wstrb[i] = 4'($urandom_range(0, 15));
        end
        fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(ln))) : -1;
        wr(4'(t), ad, ln, sz, bu, fl, int'($urandom_range(0, 2)));
      end else begin
        rd(4'(t), ad, ln, sz, bu, int'($urandom_range(0, 2)));
      end
    end

    chk("queues_drained", 64'(bq.size() + rq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
